ycr_dcache_arb: RTL and testbench

Two-master transaction arbiter in front of the shared data-cache port. Sits between the core's imem and dmem ports and the single dcache memif port. Holds a grant for a whole request/response transaction. Uses dmem-priority selection with a bounded-starvation guarantee for imem. Replaces the grant-only arbitration in the dcache path with an explicit request/ack/response sequencer.

---
 rtl/ycr_dcache_arb_pkg.sv | 25 ++
 rtl/ycr_dcache_arb.sv | 139 +++++++++++++
 tb/tb_ycr_dcache_arb.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ycr_dcache_arb_pkg.sv
// Shared definitions for the dcache two-master arbiter: memif widths/responses,
// grant encodings and the sequencer state enum.
package ycr_dcache_arb_pkg;

  localparam int YCR_IMEM_AWIDTH = 32;
  localparam int YCR_IMEM_DWIDTH = 32;

  localparam logic [1:0] YCR_MEM_RESP_NOTRDY = 2'b00;
  localparam logic [1:0] YCR_MEM_RESP_RDY_OK = 2'b01;
  localparam logic [1:0] YCR_MEM_RESP_RDY_ER = 2'b10;

  localparam logic [1:0] GNT_IMEM = 2'b00;
  localparam logic [1:0] GNT_DMEM = 2'b01;
  localparam logic [1:0] GNT_NONE = 2'b11;

  // Wide enough for the largest legal MAX_DMEM_BURST (15)
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/ycr_dcache_arb.sv
// Transaction arbiter between imem/dmem and the single dcache port: holds the
// grant from request through response, dmem-priority with bounded imem starvation.
module ycr_dcache_arb
  import ycr_dcache_arb_pkg::*;
#(
  parameter int MAX_DMEM_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst,

  input  logic                       imem_req,
  input  logic                       imem_cmd,
  input  logic [1:0]                 imem_width,
  input  logic [YCR_IMEM_AWIDTH-1:0] imem_addr,
  input  logic [YCR_IMEM_DWIDTH-1:0] imem_wdata,
  output logic                       imem_req_ack,
  output logic [YCR_IMEM_DWIDTH-1:0] imem_rdata,
  output logic [1:0]                 imem_resp,

  input  logic                       dmem_req,
  input  logic                       dmem_cmd,
  input  logic [1:0]                 dmem_width,
  input  logic [YCR_IMEM_AWIDTH-1:0] dmem_addr,
  input  logic [YCR_IMEM_DWIDTH-1:0] dmem_wdata,
  output logic                       dmem_req_ack,
  output logic [YCR_IMEM_DWIDTH-1:0] dmem_rdata,
  output logic [1:0]                 dmem_resp,

  output logic                       dcache_req,
  output logic                       dcache_cmd,
  output logic [1:0]                 dcache_width,
  output logic [YCR_IMEM_AWIDTH-1:0] dcache_addr,
  output logic [YCR_IMEM_DWIDTH-1:0] dcache_wdata,
  input  logic                       dcache_req_ack,
  input  logic [YCR_IMEM_DWIDTH-1:0] dcache_rdata,
  input  logic [1:0]                 dcache_resp,

  output logic [1:0]                 grnt,
  output logic                       busy
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DMEM_BURST);

  arb_state_e       r_state, w_state_nxt;
  logic [1:0]       r_grnt, w_grnt_nxt;
  logic [CNT_W-1:0] r_starve, w_starve_nxt;

  logic w_gnt_imem, w_gnt_dmem, w_gnt_req, w_sel_imem, w_in_req, w_in_resp;

  assign w_gnt_imem = (r_grnt == GNT_IMEM);
  assign w_gnt_dmem = (r_grnt == GNT_DMEM);
  assign w_gnt_req  = (w_gnt_imem & imem_req) | (w_gnt_dmem & dmem_req);
  assign w_in_req   = (r_state == REQ);
  assign w_in_resp  = (r_state == RESP);
  // imem wins alone, or when dmem has already used its whole burst allowance
  assign w_sel_imem = imem_req & (~dmem_req | (r_starve == MAX_CNT));

  always_comb begin
    w_state_nxt  = r_state;
    w_grnt_nxt   = r_grnt;
    w_starve_nxt = r_starve;
    case (r_state)
      IDLE: begin
        if (imem_req | dmem_req) begin
          w_state_nxt = REQ;
          if (w_sel_imem) begin
            w_grnt_nxt   = GNT_IMEM;
            w_starve_nxt = '0;
          end else begin
            w_grnt_nxt = GNT_DMEM;
            if (!imem_req)                w_starve_nxt = '0;
            else if (r_starve != MAX_CNT) w_starve_nxt = r_starve + 1'b1;
          end
        end
      end
      REQ: begin
        if (!w_gnt_req) begin
          w_state_nxt = IDLE;
          w_grnt_nxt  = GNT_NONE;
        end else if (dcache_req_ack) begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        if (dcache_resp != YCR_MEM_RESP_NOTRDY) begin
          w_state_nxt = IDLE;
          w_grnt_nxt  = GNT_NONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_grnt_nxt  = GNT_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_grnt   <= GNT_NONE;
      r_starve <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grnt   <= w_grnt_nxt;
      r_starve <= w_starve_nxt;
    end
  end

  always_comb begin
    dcache_req   = w_in_req & w_gnt_req;
    dcache_cmd   = 1'b0;
    dcache_width = '0;
    dcache_addr  = '0;
    dcache_wdata = '0;
    if (w_in_req && w_gnt_imem) begin
      dcache_cmd   = imem_cmd;
      dcache_width = imem_width;
      dcache_addr  = imem_addr;
      dcache_wdata = imem_wdata;
    end else if (w_in_req && w_gnt_dmem) begin
      dcache_cmd   = dmem_cmd;
      dcache_width = dmem_width;
      dcache_addr  = dmem_addr;
      dcache_wdata = dmem_wdata;
    end
  end

  // Ack and response pass straight through, but only to the granted master
  assign imem_req_ack = w_in_req & w_gnt_imem & imem_req & dcache_req_ack;
  assign dmem_req_ack = w_in_req & w_gnt_dmem & dmem_req & dcache_req_ack;
  assign imem_resp    = (w_in_resp & w_gnt_imem) ? dcache_resp  : YCR_MEM_RESP_NOTRDY;
  assign dmem_resp    = (w_in_resp & w_gnt_dmem) ? dcache_resp  : YCR_MEM_RESP_NOTRDY;
  assign imem_rdata   = (w_in_resp & w_gnt_imem) ? dcache_rdata : '0;
  assign dmem_rdata   = (w_in_resp & w_gnt_dmem) ? dcache_rdata : '0;

  assign grnt = r_grnt;
  assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_ycr_dcache_arb.sv
// Directed protocol scenarios, then random imem/dmem traffic against a behavioural
// cache model with a queue scoreboard and a streak-count model of the grant order.
module tb_ycr_dcache_arb;
  import ycr_dcache_arb_pkg::*;

  localparam int AW    = YCR_IMEM_AWIDTH;
  localparam int DW    = YCR_IMEM_DWIDTH;
  localparam int MAXB  = 4;
  localparam int NRAND = 1500;

  typedef struct packed {
    logic          cmd;
    logic [1:0]    width;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]         m_req, m_cmd, m_ack;
  logic [1:0][1:0]    m_width, m_resp;
  logic [1:0][AW-1:0] m_addr;
  logic [1:0][DW-1:0] m_wdata, m_rdata;

  logic          dcache_req, dcache_cmd, dcache_req_ack;
  logic [1:0]    dcache_width, dcache_resp;
  logic [AW-1:0] dcache_addr;
  logic [DW-1:0] dcache_wdata, dcache_rdata;
  logic [1:0]    grnt;
  logic          busy;

  ycr_dcache_arb #(.MAX_DMEM_BURST(MAXB)) dut (
    .clk(clk), .rst(rst),
    .imem_req(m_req[0]), .imem_cmd(m_cmd[0]), .imem_width(m_width[0]),
    .imem_addr(m_addr[0]), .imem_wdata(m_wdata[0]),
    .imem_req_ack(m_ack[0]), .imem_rdata(m_rdata[0]), .imem_resp(m_resp[0]),
    .dmem_req(m_req[1]), .dmem_cmd(m_cmd[1]), .dmem_width(m_width[1]),
    .dmem_addr(m_addr[1]), .dmem_wdata(m_wdata[1]),
    .dmem_req_ack(m_ack[1]), .dmem_rdata(m_rdata[1]), .dmem_resp(m_resp[1]),
    .dcache_req(dcache_req), .dcache_cmd(dcache_cmd), .dcache_width(dcache_width),
    .dcache_addr(dcache_addr), .dcache_wdata(dcache_wdata),
    .dcache_req_ack(dcache_req_ack), .dcache_rdata(dcache_rdata), .dcache_resp(dcache_resp),
    .grnt(grnt), .busy(busy)
  );

  int   checks = 0;
  int   fails  = 0;
  txn_t eq0[$];
  txn_t eq1[$];
  logic stop_all = 1'b0;
  time  t_end;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    fails++;
    $display("FAIL %s bound expired t=%0t", name, $time);
  endtask

  // Cache behaviour: data and status derived from the request it saw
  function automatic logic [DW-1:0] exp_rdata(input txn_t t);
    return t.addr ^ {t.wdata[15:0], t.wdata[31:16]} ^ 32'h5A5A_3C3C;
  endfunction
  function automatic logic [1:0] exp_resp(input txn_t t);
    return t.addr[3] ? YCR_MEM_RESP_RDY_ER : YCR_MEM_RESP_RDY_OK;
  endfunction

  task automatic agent(input int m);
    txn_t t;
    int   w;
    forever begin
      @(posedge clk); #1;
      if ($time > t_end) break;
      if ($urandom_range(99) < 80) begin
        t.cmd   = 1'($urandom_range(1));
        t.width = 2'($urandom_range(2));
        t.addr  = $urandom;
        t.wdata = $urandom;
        if (m == 0) eq0.push_back(t); else eq1.push_back(t);
        m_req[m] = 1'b1; m_cmd[m] = t.cmd; m_width[m] = t.width;
        m_addr[m] = t.addr; m_wdata[m] = t.wdata;
        w = 0;
        while (w < 300) begin
          @(negedge clk); w++;
          if (m_ack[m]) break;
        end
        if (!m_ack[m]) begin
          timeout(m == 0 ? "imem_ack_wait" : "dmem_ack_wait");
          m_req[m] = 1'b0;
          break;
        end
        @(posedge clk); #1;
        m_req[m] = 1'b0;
        w = 0;
        while (w < 300) begin
          @(negedge clk); w++;
          if (m_resp[m] != YCR_MEM_RESP_NOTRDY) break;
        end
        if (m_resp[m] == YCR_MEM_RESP_NOTRDY) begin
          timeout(m == 0 ? "imem_resp_wait" : "dmem_resp_wait");
          break;
        end
      end
    end
  endtask

  task automatic cache_model();
    int   st = 0;
    int   d  = 0;
    txn_t t;
    while (!stop_all) begin
      @(posedge clk); #2;
      dcache_req_ack = 1'b0;
      dcache_resp    = YCR_MEM_RESP_NOTRDY;
      dcache_rdata   = $urandom;
      if (st == 2) begin
        if (d == 0) begin
          dcache_resp  = exp_resp(t);
          dcache_rdata = exp_rdata(t);
          st = 0;
        end else d--;
      end else begin
        if (st == 0 && dcache_req) begin
          d  = int'($urandom_range(5));
          st = 1;
        end
        if (st == 1) begin
          if (!dcache_req) st = 0;
          else if (d == 0) begin
            dcache_req_ack = 1'b1;
            t  = '{dcache_cmd, dcache_width, dcache_addr, dcache_wdata};
            d  = int'($urandom_range(3));
            st = 2;
          end else d--;
        end
      end
    end
    dcache_req_ack = 1'b0;
    dcache_resp    = YCR_MEM_RESP_NOTRDY;
  endtask

  task automatic monitor();
    int         streak = 0;
    logic       pend   = 1'b0;
    logic [1:0] pexp   = GNT_NONE;
    txn_t       t;
    while (!stop_all) begin
      @(negedge clk);
      if (pend) begin
        chk("grant_order", grnt, pexp);
        chk("busy_after_grant", busy, 1'b1);
        pend = 1'b0;
      end else if (!busy) begin
        chk("idle_grnt", grnt, GNT_NONE);
        chk("idle_dcache", {dcache_req, dcache_cmd, dcache_width, dcache_addr, dcache_wdata}, '0);
        if (m_req != 2'b00) begin
          // dmem keeps winning until it has won MAXB times in a row over a waiting imem
          if (m_req == 2'b11) begin
            if (streak == MAXB) begin pexp = GNT_IMEM; streak = 0; end
            else begin pexp = GNT_DMEM; streak++; end
          end else begin
            pexp   = m_req[1] ? GNT_DMEM : GNT_IMEM;
            streak = 0;
          end
          pend = 1'b1;
        end
      end
      for (int m = 0; m < 2; m++) begin
        if (grnt != 2'(m)) begin
          chk(m == 0 ? "imem_idle_outputs" : "dmem_idle_outputs",
              {m_ack[m], m_resp[m], m_rdata[m]}, {1'b0, YCR_MEM_RESP_NOTRDY, {DW{1'b0}}});
        end else if (busy) begin
          if (!m_req[m]) chk("dcache_req_after_drop", dcache_req, 1'b0);
          if (dcache_req) chk("ack_forward", m_ack[m], dcache_req_ack);
          if (dcache_req && dcache_req_ack) begin
            if ((m == 0 ? eq0.size() : eq1.size()) == 0) timeout("ack_without_request");
            else begin
              t = (m == 0) ? eq0[0] : eq1[0];
              chk("dcache_fields", {dcache_cmd, dcache_width, dcache_addr, dcache_wdata}, t);
            end
          end
        end
        if (m_resp[m] != YCR_MEM_RESP_NOTRDY) begin
          if ((m == 0 ? eq0.size() : eq1.size()) == 0) timeout("resp_without_request");
          else begin
            t = (m == 0) ? eq0.pop_front() : eq1.pop_front();
            chk("resp_code", m_resp[m], exp_resp(t));
            chk("resp_rdata", m_rdata[m], exp_rdata(t));
          end
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    m_req = '0; m_cmd = '0; m_width = '0; m_addr = '0; m_wdata = '0;
    dcache_req_ack = 1'b0; dcache_resp = YCR_MEM_RESP_NOTRDY; dcache_rdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_grnt", grnt, GNT_NONE);
    chk("rst_busy", busy, 1'b0);
    chk("rst_dcache", {dcache_req, dcache_cmd, dcache_width, dcache_addr, dcache_wdata}, '0);
    chk("rst_masters", {m_ack, m_resp, m_rdata}, '0);

    // imem-only read
    step(); m_req[0] = 1'b1; m_addr[0] = 32'h100; m_width[0] = 2'd2;
    @(negedge clk); chk("bubble_no_req", dcache_req, 1'b0);
    step(); dcache_req_ack = 1'b1;
    @(negedge clk);
    chk("rd_dcache_req", dcache_req, 1'b1);
    chk("rd_addr", dcache_addr, 32'h100);
    chk("rd_grnt", grnt, GNT_IMEM);
    chk("rd_ack", m_ack, 2'b01);
    step(); dcache_req_ack = 1'b0; m_req[0] = 1'b0;
    @(negedge clk); chk("rd_resp_wait", {dcache_req, m_resp[0]}, {1'b0, YCR_MEM_RESP_NOTRDY});
    step(); dcache_resp = YCR_MEM_RESP_RDY_OK; dcache_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("rd_resp", {m_resp[0], m_rdata[0]}, {YCR_MEM_RESP_RDY_OK, 32'hDEADBEEF});
    chk("rd_other", {m_resp[1], m_rdata[1]}, {YCR_MEM_RESP_NOTRDY, 32'h0});
    step(); dcache_resp = YCR_MEM_RESP_NOTRDY; dcache_rdata = '0;
    @(negedge clk); chk("rd_done", {grnt, busy}, {GNT_NONE, 1'b0});

    // dmem write, reset while waiting for the response
    step(); m_req[1] = 1'b1; m_cmd[1] = 1'b1; m_addr[1] = 32'h200; m_wdata[1] = 32'h1234_5678;
    step(); dcache_req_ack = 1'b1;
    @(negedge clk);
    chk("wr_fields", {dcache_cmd, dcache_addr, dcache_wdata}, {1'b1, 32'h200, 32'h1234_5678});
    chk("wr_ack", {grnt, m_ack}, {GNT_DMEM, 2'b10});
    step(); dcache_req_ack = 1'b0; m_req[1] = 1'b0; rst = 1'b1;
    @(negedge clk); chk("wr_in_resp", busy, 1'b1);
    step(); rst = 1'b0; dcache_resp = YCR_MEM_RESP_RDY_OK; dcache_rdata = 32'h0000_CAFE;
    @(negedge clk);
    chk("rst_resp_state", {grnt, busy}, {GNT_NONE, 1'b0});
    chk("stray_resp", {m_resp, m_rdata}, '0);
    step(); dcache_resp = YCR_MEM_RESP_NOTRDY; dcache_rdata = '0;

    // granted dmem drops its request before ack; waiting imem goes next
    step(); m_req = 2'b11; m_cmd = 2'b00; m_addr[0] = 32'h300; m_addr[1] = 32'h400;
    step();
    @(negedge clk); chk("pv_grant", {grnt, dcache_addr}, {GNT_DMEM, 32'h400});
    step(); m_req[1] = 1'b0;
    @(negedge clk); chk("pv_dropped", {dcache_req, m_ack, busy}, {1'b0, 2'b00, 1'b1});
    step();
    @(negedge clk); chk("pv_idle", {grnt, busy}, {GNT_NONE, 1'b0});
    step();
    @(negedge clk); chk("pv_imem", {grnt, dcache_addr, dcache_req}, {GNT_IMEM, 32'h300, 1'b1});
    dcache_req_ack = 1'b1;
    step(); dcache_req_ack = 1'b0; m_req[0] = 1'b0; dcache_resp = YCR_MEM_RESP_RDY_ER;
    @(negedge clk); chk("pv_err_resp", m_resp[0], YCR_MEM_RESP_RDY_ER);
    step(); dcache_resp = YCR_MEM_RESP_NOTRDY;
    @(negedge clk); chk("pv_done", busy, 1'b0);

    // randomized traffic
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    t_end = $time + NRAND * 10;
    fork
      begin
        fork
          agent(0);
          agent(1);
        join
        repeat (12) @(posedge clk);
        stop_all = 1'b1;
      end
      cache_model();
      monitor();
    join
    chk("imem_queue_drained", eq0.size(), 0);
    chk("dmem_queue_drained", eq1.size(), 0);
    chk("final_idle", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
